// File: rtl/fuel_pump_ctrl.sv
// Fuel-pump immobiliser: arms on ignition+switch+pedal, primes for a bounded
// window awaiting engine_run, and locks out after repeated failed ignitions.
module fuel_pump_ctrl #(
  parameter int PRIME_CYCLES = 4,
  parameter int MAX_TRIES    = 3,
  parameter int LOCK_CYCLES  = 8,
  localparam int CNT_MAX     = (PRIME_CYCLES > LOCK_CYCLES) ? PRIME_CYCLES : LOCK_CYCLES,
  localparam int CW          = $clog2(CNT_MAX + 1),
  localparam int TW          = $clog2(MAX_TRIES + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ignition,
  input  logic          switch,
  input  logic          pedal,
  input  logic          engine_run,
  output logic          status,
  output logic [1:0]    state,
  output logic          locked,
  output logic [TW-1:0] tries
);

  localparam logic [1:0] ST_OFF     = 2'd0;
  localparam logic [1:0] ST_PRIME   = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_LOCKOUT = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tries_q, tries_d;
  logic          ign_prev_q, ign_prev_d;
  logic          arm;
  logic          ign_rise;

  assign arm      = ignition & switch & pedal;
  assign ign_rise = ignition & ~ign_prev_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tries_d    = tries_q;
    ign_prev_d = ignition;
    case (state_q)
      ST_OFF: begin
        // Arming takes precedence, so a rising edge that arms is never a failure.
        if (arm) begin
          state_d = ST_PRIME;
          cnt_d   = CW'(PRIME_CYCLES - 1);
          tries_d = '0;
        end else if (ign_rise) begin
          if (tries_q == TW'(MAX_TRIES - 1)) begin
            state_d = ST_LOCKOUT;
            cnt_d   = CW'(LOCK_CYCLES - 1);
            tries_d = '0;
          end else begin
            tries_d = tries_q + TW'(1);
          end
        end
      end
      ST_PRIME: begin
        if (!ignition) begin
          state_d = ST_OFF;
        end else if (engine_run) begin
          state_d = ST_RUN;
        end else if (cnt_q == '0) begin
          state_d = ST_OFF;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RUN: begin
        // A stall drops straight to OFF; the driver must re-arm.
        if (!ignition || !engine_run) begin
          state_d = ST_OFF;
        end
      end
      ST_LOCKOUT: begin
        tries_d = '0;
        if (cnt_q == '0) begin
          state_d = ST_OFF;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_OFF;
      cnt_q      <= '0;
      tries_q    <= '0;
      ign_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tries_q    <= tries_d;
      ign_prev_q <= ign_prev_d;
    end
  end

  assign status = (state_q == ST_PRIME) | (state_q == ST_RUN);
  assign locked = (state_q == ST_LOCKOUT);
  assign state  = state_q;
  assign tries  = tries_q;

endmodule

// File: tb/tb_fuel_pump_ctrl.sv
// Bench for fuel_pump_ctrl: directed scenarios plus random traffic, all
// checked against a cycle-level behavioural model of the controller.
module tb_fuel_pump_ctrl;

  localparam int P  = 4;
  localparam int MT = 3;
  localparam int LC = 8;
  localparam int TW = $clog2(MT + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          ignition = 1'b0, switch = 1'b0, pedal = 1'b0, engine_run = 1'b0;
  logic          status, locked;
  logic [1:0]    state;
  logic [TW-1:0] tries;

  int errors = 0;
  int checks = 0;

  // Model: mode 0=off 1=priming 2=running 3=locked out; left = cycles still to show.
  int m_mode, m_left, m_tries;
  bit m_prev;

  fuel_pump_ctrl dut (
    .clock(clock), .reset(reset), .ignition(ignition), .switch(switch),
    .pedal(pedal), .engine_run(engine_run), .status(status), .state(state),
    .locked(locked), .tries(tries)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_tries = 0; m_prev = 0;
  endtask

  task automatic model_step(input bit ig, input bit sw, input bit pd, input bit er);
    bit arm_now, rise;
    arm_now = ig && sw && pd;
    rise    = ig && !m_prev;
    m_prev  = ig;
    if (m_mode == 0) begin
      if (arm_now) begin
        m_mode = 1; m_left = P; m_tries = 0;
      end else if (rise) begin
        m_tries++;
        if (m_tries >= MT) begin
          m_mode = 3; m_left = LC; m_tries = 0;
        end
      end
    end else if (m_mode == 1) begin
      if (!ig) m_mode = 0;
      else if (er) m_mode = 2;
      else begin
        m_left--;
        if (m_left == 0) m_mode = 0;
      end
    end else if (m_mode == 2) begin
      if (!ig || !er) m_mode = 0;
    end else begin
      m_left--;
      if (m_left == 0) m_mode = 0;
    end
  endtask

  task automatic cyc(input bit ig, input bit sw, input bit pd, input bit er);
    ignition = ig; switch = sw; pedal = pd; engine_run = er;
    @(posedge clock);
    model_step(ig, sw, pd, er);
    #1;
  endtask

  function automatic logic [TW+3:0] model_vec();
    model_vec = {(m_mode == 1 || m_mode == 2) ? 1'b1 : 1'b0, 2'(m_mode),
                 (m_mode == 3) ? 1'b1 : 1'b0, TW'(m_tries)};
  endfunction

  task automatic test_reset();
    ignition = 0; switch = 0; pedal = 0; engine_run = 0;
    reset = 1;
    model_reset();
    @(posedge clock); #1;
    checks++;
    if ({status, state, locked, tries} !== '0) begin
      errors++;
      $display("FAIL reset_state got=%b want=0", {status, state, locked, tries});
    end
    @(negedge clock); reset = 0;
  endtask

  task automatic test_prime_timeout();
    cyc(0, 0, 0, 0);
    cyc(1, 1, 1, 0);
    checks++;
    if (state !== 2'd1 || status !== 1'b1) begin
      errors++;
      $display("FAIL prime_entry got state=%0d status=%b want 1/1", state, status);
    end
    for (int i = 1; i <= P; i++) begin
      cyc(1, 0, 0, 0);
      checks++;
      if ({status, state, locked, tries} !== model_vec() || status !== (i < P)) begin
        errors++;
        $display("FAIL prime_window[%0d] got=%b want=%b", i, {status, state, locked, tries}, model_vec());
      end
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_run();
    cyc(1, 1, 1, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    checks++;
    if (state !== 2'd2 || status !== 1'b1 || {status, state, locked, tries} !== model_vec()) begin
      errors++;
      $display("FAIL run_entry got state=%0d status=%b want 2/1", state, status);
    end
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 0);
    checks++;
    if (state !== 2'd0 || status !== 1'b0) begin
      errors++;
      $display("FAIL run_stall got state=%0d status=%b want 0/0", state, status);
    end
    cyc(1, 1, 1, 1);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    checks++;
    if (state !== 2'd0 || {status, state, locked, tries} !== model_vec()) begin
      errors++;
      $display("FAIL run_ign_drop got state=%0d want 0", state);
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_lockout();
    for (int p = 1; p <= MT; p++) begin
      cyc(1, 0, 0, 0);
      checks++;
      if (p < MT) begin
        if (tries !== TW'(p) || state !== 2'd0) begin
          errors++;
          $display("FAIL lock_tries[%0d] got tries=%0d state=%0d want %0d/0", p, tries, state, p);
        end
        cyc(0, 0, 0, 0);
      end else if (state !== 2'd3 || locked !== 1'b1 || tries !== '0 || status !== 1'b0) begin
        errors++;
        $display("FAIL lock_entry got state=%0d locked=%b tries=%0d want 3/1/0", state, locked, tries);
      end
    end
    for (int k = 1; k <= LC; k++) begin
      cyc(1, 1, 1, 1);
      checks++;
      if (locked !== (k < LC) || {status, state, locked, tries} !== model_vec()) begin
        errors++;
        $display("FAIL lock_hold[%0d] got locked=%b state=%0d", k, locked, state);
      end
    end
    cyc(1, 1, 1, 0);
    checks++;
    if (state !== 2'd1 || status !== 1'b1) begin
      errors++;
      $display("FAIL lock_exit_arm got state=%0d want 1", state);
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_arm_clears_tries();
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    checks++;
    if (tries !== TW'(2)) begin
      errors++;
      $display("FAIL tries_two got=%0d want=2", tries);
    end
    cyc(1, 1, 1, 0);
    checks++;
    if (tries !== '0 || state !== 2'd1) begin
      errors++;
      $display("FAIL arm_clears got tries=%0d state=%0d want 0/1", tries, state);
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_expiry_race();
    cyc(1, 1, 1, 0);
    for (int i = 0; i < P - 1; i++) cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL expiry_run got state=%0d want 2", state);
    end
    cyc(0, 0, 0, 0);
    cyc(1, 1, 1, 0);
    for (int i = 0; i < P - 1; i++) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    checks++;
    if (state !== 2'd0 || {status, state, locked, tries} !== model_vec()) begin
      errors++;
      $display("FAIL expiry_igoff got state=%0d want 0", state);
    end
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    for (int p = 0; p < MT; p++) begin
      cyc(1, 0, 0, 0);
      if (p < MT - 1) cyc(0, 0, 0, 0);
    end
    cyc(1, 0, 0, 0);
    #2 reset = 1;
    #1;
    checks++;
    if ({status, state, locked, tries} !== '0) begin
      errors++;
      $display("FAIL areset_lockout got=%b want=0", {status, state, locked, tries});
    end
    @(negedge clock);
    model_reset();
    reset = 0;
    cyc(1, 0, 0, 0);
    checks++;
    if ({status, state, locked, tries} !== model_vec()) begin
      errors++;
      $display("FAIL areset_release got=%b want=%b", {status, state, locked, tries}, model_vec());
    end
    cyc(0, 0, 0, 0);
    cyc(1, 1, 1, 1);
    cyc(1, 0, 0, 1);
    #2 reset = 1;
    #1;
    checks++;
    if ({status, state, locked, tries} !== '0) begin
      errors++;
      $display("FAIL areset_run got=%b want=0", {status, state, locked, tries});
    end
    @(negedge clock);
    model_reset();
    reset = 0;
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_random();
    bit ig, sw, pd, er;
    ig = 0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) < 25) ig = ~ig;
      sw = ($urandom_range(0, 99) < 40);
      pd = ($urandom_range(0, 99) < 60);
      er = ($urandom_range(0, 99) < 35);
      if ($urandom_range(0, 199) == 0) begin
        @(negedge clock);
        reset = 1; #1;
        model_reset();
        @(negedge clock);
        reset = 0;
      end
      cyc(ig, sw, pd, er);
      checks++;
      if ({status, state, locked, tries} !== model_vec()) begin
        errors++;
        $display("FAIL random[%0d] got=%b want=%b", n, {status, state, locked, tries}, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_prime_timeout();
    test_run();
    test_lockout();
    test_arm_clears_tries();
    test_expiry_race();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
